// File: rtl/interrupt_controller.sv
//==============================================================================
// Module   : interrupt_controller
// Purpose  : Collects rising-edge interrupt requests from peripherals into
//            pending bits, masks them per source, and presents a single level
//            interrupt to the CPU. A claim/complete handshake serialises
//            service to one source at a time. Programmed over the peripheral
//            bus slave interface.
// Ports    : clk, rst          - clock, async active-high reset
//            src[IRQ_NUM]      - interrupt sources (bit 0 = timer pulse)
//            irq               - level interrupt to CPU
//            addr/w_rb/acc     - byte address, 1=write/0=read, access size
//            wdata/rdata       - write data / registered read data
//            req/resp/fault    - access request, registered completion,
//                                combinational invalid-access flag
// Options  : define INTC_SWI_EN to implement the software-interrupt register
//            at 0x10; otherwise any access to 0x10 faults.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef INTC_SIZE
`define INTC_SIZE 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module interrupt_controller #(
  parameter int IRQ_NUM = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IRQ_NUM-1:0]              src,
  output logic                            irq,
  input  logic [$clog2(`INTC_SIZE)-1:0]   addr,
  input  logic                            w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0]       acc,
  output logic [`BUS_WIDTH-1:0]           rdata,
  input  logic [`BUS_WIDTH-1:0]           wdata,
  input  logic                            req,
  output logic                            resp,
  output logic                            fault
);

  localparam int c_AW = $clog2(`INTC_SIZE);

  localparam logic [c_AW-1:0] c_ADDR_PEND  = c_AW'('h00);
  localparam logic [c_AW-1:0] c_ADDR_EN    = c_AW'('h04);
  localparam logic [c_AW-1:0] c_ADDR_CLAIM = c_AW'('h08);
  localparam logic [c_AW-1:0] c_ADDR_CPLT  = c_AW'('h0C);
  localparam logic [c_AW-1:0] c_ADDR_SWI   = c_AW'('h10);
  localparam logic [c_AW-1:0] c_ADDR_END   = c_AW'('h14);

  // Service state machine: IDLE means no source is being serviced (busy=0)
  localparam logic [0:0] c_IDLE    = 1'b0;
  localparam logic [0:0] c_SERVICE = 1'b1;

  logic [IRQ_NUM-1:0] r_src_q;
  logic [IRQ_NUM-1:0] r_pend;
  logic [IRQ_NUM-1:0] r_en;
  logic [0:0]         r_state;
  logic [4:0]         r_act_id;
  logic               r_resp;
  logic [31:0]        r_rdata;

  logic w_sel_pend, w_sel_en, w_sel_claim, w_sel_cplt, w_sel_swi;
  logic w_invld, w_valid, w_rd, w_wr, w_busy, w_any, w_claim;
  logic [IRQ_NUM-1:0] w_pe, w_hit, w_clr, w_ev, w_swi_set, w_pend_nxt;
  logic [4:0]  w_idx;
  logic [31:0] w_pend_ext, w_en_ext, w_rd_data;
  logic        w_unused;

  // Address decode and access validation
  assign w_sel_pend  = (addr == c_ADDR_PEND);
  assign w_sel_en    = (addr == c_ADDR_EN);
  assign w_sel_claim = (addr == c_ADDR_CLAIM);
  assign w_sel_cplt  = (addr == c_ADDR_CPLT);
  assign w_sel_swi   = (addr == c_ADDR_SWI);

`ifdef INTC_SWI_EN
  assign w_invld = (addr[1:0] != 2'b00) | (acc != `BUS_ACC_4B) |
                   (addr >= c_ADDR_END) | (w_sel_claim & w_rb) |
                   (w_sel_swi & ~w_rb);
`else
  assign w_invld = (addr[1:0] != 2'b00) | (acc != `BUS_ACC_4B) |
                   (addr >= c_ADDR_END) | (w_sel_claim & w_rb) | w_sel_swi;
`endif

  assign fault   = req & w_invld;
  assign w_valid = req & ~w_invld;
  assign w_rd    = w_valid & ~w_rb;
  assign w_wr    = w_valid & w_rb;

  assign w_busy  = (r_state == c_SERVICE);
  assign w_pe    = r_pend & r_en;
  assign w_any   = |w_pe;
  assign irq     = ~w_busy & w_any;

  // Lowest set index wins: scan from the top so the last hit is the lowest
  always_comb begin
    w_idx = 5'd0;
    w_hit = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (w_pe[i]) begin
        w_idx    = 5'(i);
        w_hit    = '0;
        w_hit[i] = 1'b1;
      end
    end
  end

  assign w_claim = w_rd & w_sel_claim & w_any;

`ifdef INTC_SWI_EN
  assign w_swi_set = (w_wr & w_sel_swi) ? wdata[IRQ_NUM-1:0] : '0;
`else
  assign w_swi_set = '0;
`endif

  // Clears are applied first so that a same-cycle edge or SWI set wins
  assign w_ev       = src & ~r_src_q;
  assign w_clr      = ((w_wr & w_sel_pend) ? wdata[IRQ_NUM-1:0] : '0) |
                      (w_claim ? w_hit : '0);
  assign w_pend_nxt = (r_pend & ~w_clr) | w_ev | w_swi_set;

  // Read data mux; bits at and above IRQ_NUM read as zero
  always_comb begin
    w_pend_ext = '0;
    w_en_ext   = '0;
    w_pend_ext[IRQ_NUM-1:0] = r_pend;
    w_en_ext[IRQ_NUM-1:0]   = r_en;
    w_rd_data  = '0;
    if (w_sel_pend)       w_rd_data = w_pend_ext;
    else if (w_sel_en)    w_rd_data = w_en_ext;
    else if (w_sel_claim) w_rd_data = w_any ? {1'b1, 26'd0, w_idx} : 32'd0;
    else if (w_sel_cplt)  w_rd_data = {w_busy, 26'd0, r_act_id};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_q  <= '0;
      r_pend   <= '0;
      r_en     <= '0;
      r_state  <= c_IDLE;
      r_act_id <= 5'd0;
      r_resp   <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_src_q <= src;
      r_pend  <= w_pend_nxt;
      r_resp  <= w_valid;
      if (w_wr & w_sel_en) r_en     <= wdata[IRQ_NUM-1:0];
      if (w_rd)            r_rdata  <= w_rd_data;
      if (w_claim)         r_act_id <= w_idx;
      case (r_state)
        c_IDLE:    if (w_claim)            r_state <= c_SERVICE;
        c_SERVICE: if (w_wr & w_sel_cplt)  r_state <= c_IDLE;
        default:                           r_state <= c_IDLE;
      endcase
    end
  end

  assign resp  = r_resp;
  assign rdata = r_rdata;

  // Upper write-data bits have no function
  assign w_unused = ^wdata;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
//==============================================================================
// Module   : tb_interrupt_controller
// Purpose  : Self-checking bench for interrupt_controller: directed scenarios
//            followed by randomized traffic against a behavioural model, with
//            bus responses checked through a scoreboard queue.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef INTC_SIZE
`define INTC_SIZE 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_interrupt_controller;

  localparam int          c_N    = 4;
  localparam logic [1:0]  c_ACC4 = `BUS_ACC_4B;
  localparam logic [4:0]  c_PEND = 5'h00, c_EN = 5'h04, c_CLAIM = 5'h08,
                          c_CPLT = 5'h0C, c_SWI = 5'h10;

  logic            clk = 1'b0;
  logic            rst;
  logic [c_N-1:0]  src;
  logic            irq;
  logic [4:0]      addr;
  logic            w_rb;
  logic [1:0]      acc;
  logic [31:0]     rdata, wdata;
  logic            req, resp, fault;

  interrupt_controller #(.IRQ_NUM(c_N)) dut (
    .clk(clk), .rst(rst), .src(src), .irq(irq), .addr(addr), .w_rb(w_rb),
    .acc(acc), .rdata(rdata), .wdata(wdata), .req(req), .resp(resp),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit [c_N-1:0] m_pend, m_en, m_srcq;
  bit           m_busy;
  bit [4:0]     m_act;

  typedef struct { int cyc; bit is_rd; logic [31:0] data; } exp_t;
  exp_t q[$];

  int n_cmp = 0, n_err = 0;
  int cyc   = 0;
  bit rst_next;
  logic [c_N-1:0] s_drv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_srcq = '0; m_busy = 1'b0; m_act = 5'd0;
  endtask

  function automatic bit invalid(input bit wr, input logic [4:0] a, input logic [1:0] ac);
    bit v;
    v = (a[1:0] != 2'b00) || (ac != c_ACC4) || (a >= 5'h14) ||
        (a == c_CLAIM && wr) || (a == c_SWI && !wr);
`ifndef INTC_SWI_EN
    v = v || (a == c_SWI);
`endif
    return v;
  endfunction

  // One clock cycle of stimulus: drive at the falling edge, check fault,
  // then advance the model to the state after the next rising edge.
  task automatic step(input bit rq, input bit wr, input logic [4:0] a,
                      input logic [1:0] ac, input logic [31:0] wd,
                      input bit use_k, input logic [31:0] kval);
    bit             inv, found;
    bit [c_N-1:0]   ev, clr, sw, pe;
    logic [31:0]    rdv;
    exp_t           e;
    @(negedge clk);
    rst = rst_next;
    if (rst_next) model_reset();
    src = s_drv; req = rq; w_rb = wr; addr = a; acc = ac; wdata = wd;
    inv = invalid(wr, a, ac);
    #1;
    chk("fault", {31'd0, fault}, {31'd0, rq & inv});
    if (!rst_next) begin
      ev = s_drv & ~m_srcq;
      clr = '0; sw = '0; rdv = 32'd0;
      if (rq && !inv) begin
        if (!wr) begin
          if (a == c_PEND) rdv = 32'(m_pend);
          else if (a == c_EN) rdv = 32'(m_en);
          else if (a == c_CPLT) rdv = {m_busy, 26'd0, m_act};
          else if (a == c_CLAIM) begin
            pe = m_pend & m_en;
            found = 1'b0;
            for (int k = 0; k < c_N; k++) begin
              if (!found && pe[k]) begin
                found = 1'b1;
                rdv = 32'h8000_0000 | 32'(k);
                clr[k] = 1'b1;
                m_busy = 1'b1;
                m_act = 5'(k);
              end
            end
          end
        end else begin
          if (a == c_PEND) clr = wd[c_N-1:0];
          else if (a == c_EN) m_en = wd[c_N-1:0];
          else if (a == c_CPLT) m_busy = 1'b0;
          else if (a == c_SWI) sw = wd[c_N-1:0];
        end
        e.cyc = cyc + 1; e.is_rd = !wr; e.data = use_k ? kval : rdv;
        q.push_back(e);
      end
      m_pend = (m_pend & ~clr) | ev | sw;
      m_srcq = s_drv;
    end
  endtask

  task automatic idle();                                       step(0, 0, 5'h0, c_ACC4, 32'd0, 0, 32'd0); endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d); step(1, 1, a, c_ACC4, d, 0, 32'd0);     endtask
  task automatic rdm(input logic [4:0] a);                      step(1, 0, a, c_ACC4, 32'd0, 0, 32'd0); endtask
  task automatic rdx(input logic [4:0] a, input logic [31:0] k); step(1, 0, a, c_ACC4, 32'd0, 1, k);    endtask

  // Monitor: compares resp/rdata against the scoreboard and irq against the model
  always @(posedge clk) begin
    bit   exp_r;
    exp_t e;
    #1;
    exp_r = (q.size() > 0) && (q[0].cyc == cyc);
    chk("resp", {31'd0, resp}, {31'd0, exp_r});
    if (exp_r) begin
      e = q.pop_front();
      if (e.is_rd && resp === 1'b1) chk("rdata", rdata, e.data);
    end
    chk("irq", {31'd0, irq}, {31'd0, !m_busy && ((m_pend & m_en) != 0)});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst_next = 1'b1; s_drv = '0;
    src = '0; req = 1'b0; w_rb = 1'b0; addr = '0; acc = c_ACC4; wdata = '0;
    model_reset();
    #1;
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_resp", {31'd0, resp}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    idle(); idle();
    rst_next = 1'b0;
    idle();
    rdx(c_PEND, 32'd0); rdx(c_EN, 32'd0); rdx(c_CPLT, 32'd0);

    // Timer pulse on source 0
    wr(c_EN, 32'h1);
    s_drv = 4'h1; idle(); s_drv = 4'h0; idle();
    rdx(c_PEND, 32'h1);
    rdx(c_CLAIM, 32'h8000_0000);
    wr(c_CPLT, 32'h0);
    rdx(c_PEND, 32'h0);

    // Priority and masking
    wr(c_EN, 32'h8);
    s_drv = 4'hA; idle();
    rdx(c_CLAIM, 32'h8000_0003);
    wr(c_CPLT, 32'h0);
    s_drv = 4'h0; idle(); s_drv = 4'hA; idle();
    wr(c_EN, 32'hA);
    rdx(c_CLAIM, 32'h8000_0001);
    rdx(c_PEND, 32'h8);
    wr(c_CPLT, 32'h0);
    wr(c_EN, 32'h0);
    rdx(c_CLAIM, 32'h0);
    rdx(c_CPLT, 32'h1);
    wr(c_PEND, 32'hF);
    s_drv = 4'h0; idle();

    // Collisions: edge vs W1C, edge vs claim; held source gives no new event
    wr(c_EN, 32'h1);
    s_drv = 4'h1; wr(c_PEND, 32'h1);
    rdx(c_PEND, 32'h1);
    rdx(c_CLAIM, 32'h8000_0000);
    repeat (10) idle();
    rdx(c_PEND, 32'h0);
    wr(c_CPLT, 32'h0);
    s_drv = 4'h0; idle(); s_drv = 4'h1; idle(); s_drv = 4'h0; idle();
    s_drv = 4'h1; rdx(c_CLAIM, 32'h8000_0000);
    rdx(c_PEND, 32'h1);
    wr(c_CPLT, 32'h0);

    // Faulted accesses leave state untouched
    step(1, 1, 5'h02, c_ACC4, 32'hF, 0, 32'd0);
    step(1, 1, c_EN, 2'd1, 32'h0, 0, 32'd0);
    step(1, 1, c_CLAIM, c_ACC4, 32'h0, 0, 32'd0);
    step(1, 0, 5'h14, c_ACC4, 32'h0, 0, 32'd0);
    step(1, 1, 5'h14, c_ACC4, 32'hF, 0, 32'd0);
    rdx(c_PEND, 32'h1);
    rdx(c_EN, 32'h1);
    rdx(c_CPLT, 32'h0);

    // Software interrupt register
    wr(c_PEND, 32'hF);
    step(1, 1, c_SWI, c_ACC4, 32'h6, 0, 32'd0);
`ifdef INTC_SWI_EN
    rdx(c_PEND, 32'h6);
`else
    rdx(c_PEND, 32'h0);
`endif
    step(1, 0, c_SWI, c_ACC4, 32'h0, 0, 32'd0);
    wr(c_PEND, 32'hF);

    // Asynchronous reset with pend=0x5, busy=1 and an access in flight
    s_drv = 4'h0; idle(); s_drv = 4'h5; idle(); s_drv = 4'h0; idle();
    s_drv = 4'h1; rdx(c_CLAIM, 32'h8000_0000);
    rdx(c_PEND, 32'h5);
    #2;
    rst = 1'b1; rst_next = 1'b1;
    model_reset();
    q.delete();
    #1;
    chk("async_irq", {31'd0, irq}, 32'd0);
    chk("async_resp", {31'd0, resp}, 32'd0);
    chk("async_rdata", rdata, 32'd0);
    s_drv = 4'h0;
    rdm(c_PEND);
    idle();
    rst_next = 1'b0;
    idle();
    rdx(c_PEND, 32'h0); rdx(c_EN, 32'h0); rdx(c_CPLT, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [4:0] tbl [8];
      logic [4:0] a;
      tbl = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h02, 5'h08};
      for (int b = 0; b < c_N; b++)
        if ($urandom_range(0, 7) == 0) s_drv[b] = ~s_drv[b];
      if ($urandom_range(0, 1) == 1) begin
        a = tbl[$urandom_range(0, 7)];
        step(1, 1'($urandom_range(0, 1)), a,
             ($urandom_range(0, 7) == 0) ? 2'd1 : c_ACC4, $urandom, 0, 32'd0);
      end else begin
        idle();
      end
    end

    s_drv = '0;
    idle(); idle(); idle();
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
